// File: rtl/avalon_ahb_bridge.sv
// avalon_ahb_bridge: Avalon-MM slave to AHB-Lite master bridge. One transaction is
// outstanding at a time. Byteenable selects HSIZE and the low HADDR bits, and
// unsupported byteenable patterns never reach the AHB bus.
// Optional build macro AVL_AHB_TIMEOUT_EN adds a data-phase watchdog. It aborts the
// transfer after TIMEOUT_CYCLES stalled (HREADY-low) cycles.
module avalon_ahb_bridge #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        readdatavalid,
   output logic [1:0]  response,
   output logic        wr_err,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   typedef struct packed {
      logic       ok;
      logic [2:0] size;
      logic [1:0] lo;
   } be_dec_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;

   // Map an Avalon byteenable onto AHB size and the low two address bits.
   function automatic be_dec_t decode_be(input logic [3:0] be);
      be_dec_t d;
      d.ok   = 1'b1;
      d.size = 3'b000;
      d.lo   = 2'b00;
      case (be)
         4'b1111: begin d.size = 3'b010; d.lo = 2'b00; end
         4'b0011: begin d.size = 3'b001; d.lo = 2'b00; end
         4'b1100: begin d.size = 3'b001; d.lo = 2'b10; end
         4'b0001: begin d.size = 3'b000; d.lo = 2'b00; end
         4'b0010: begin d.size = 3'b000; d.lo = 2'b01; end
         4'b0100: begin d.size = 3'b000; d.lo = 2'b10; end
         4'b1000: begin d.size = 3'b000; d.lo = 2'b11; end
         default: begin d.ok = 1'b0; d.size = 3'b000; d.lo = 2'b00; end
      endcase
      return d;
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic        waitrequest_r;
   logic [31:0] readdata_r;
   logic        readdatavalid_r;
   logic [1:0]  response_r;
   logic        wr_err_r;
   logic [31:0] haddr_r;
   logic [1:0]  htrans_r;
   logic [2:0]  hsize_r;
   logic        hwrite_r;
   logic [31:0] hwdata_r;
   logic        write_dir_r;

   be_dec_t     be_dec_s;
   logic        accept_s;
   logic        rd_load_s;
   logic [31:0] rd_data_s;
   logic        rd_err_s;
   logic        wr_err_s;
   logic        timeout_s;
   logic        unused_addr_lo_s;

   // The low address bits are implied by byteenable, so address[1:0] is not used.
   assign unused_addr_lo_s = ^address[1:0];

   // Reject a zero watchdog limit at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("avalon_ahb_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   assign be_dec_s = decode_be(byteenable);
   // The first cycle after reset sits in IDLE with waitrequest still high and is not an acceptance.
   assign accept_s = (state_r == ST_IDLE) && !waitrequest_r && (read || write);

`ifdef AVL_AHB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_r;

   // Stall counter: zero outside DATA, counts HREADY-low cycles inside DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != ST_DATA) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (!HREADY) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // This stalled cycle is the one that brings the count to the limit.
   assign timeout_s = (state_r == ST_DATA) && !HREADY &&
                      (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic plus read-result and write-error selection.
   always_comb begin
      state_nxt_s = state_r;
      rd_load_s   = 1'b0;
      rd_data_s   = 32'h0000_0000;
      rd_err_s    = 1'b0;
      wr_err_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (be_dec_s.ok) begin
                  state_nxt_s = ST_ADDR;
               end else begin
                  // Unsupported lanes: no bus transfer, just report the error.
                  state_nxt_s = ST_RESP;
                  if (write) begin
                     wr_err_s = 1'b1;
                  end else begin
                     rd_load_s = 1'b1;
                     rd_err_s  = 1'b1;
                  end
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (HREADY) begin
               if (write_dir_r) begin
                  state_nxt_s = ST_IDLE;
                  wr_err_s    = HRESP;
               end else begin
                  state_nxt_s = ST_RESP;
                  rd_load_s   = 1'b1;
                  rd_data_s   = HRDATA;
                  rd_err_s    = HRESP;
               end
            end else if (timeout_s) begin
               if (write_dir_r) begin
                  state_nxt_s = ST_IDLE;
                  wr_err_s    = 1'b1;
               end else begin
                  state_nxt_s = ST_RESP;
                  rd_load_s   = 1'b1;
                  rd_err_s    = 1'b1;
               end
            end else begin
               // HRESP with HREADY low is the first half of an error; keep waiting.
               state_nxt_s = ST_DATA;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Registered Avalon and AHB outputs and the captured command.
   always_ff @(posedge clk) begin
      if (rst) begin
         waitrequest_r   <= 1'b1;
         readdata_r      <= 32'h0000_0000;
         readdatavalid_r <= 1'b0;
         response_r      <= RESP_OKAY;
         wr_err_r        <= 1'b0;
         haddr_r         <= 32'h0000_0000;
         htrans_r        <= HTRANS_IDLE;
         hsize_r         <= 3'b000;
         hwrite_r        <= 1'b0;
         hwdata_r        <= 32'h0000_0000;
         write_dir_r     <= 1'b0;
      end else begin
         waitrequest_r   <= (state_nxt_s != ST_IDLE);
         htrans_r        <= (state_nxt_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
         readdatavalid_r <= rd_load_s;
         wr_err_r        <= wr_err_s;
         if (rd_load_s) begin
            readdata_r <= rd_data_s;
            response_r <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
         end else begin
            readdata_r <= readdata_r;
            response_r <= response_r;
         end
         if (accept_s) begin
            // Write wins when read and write arrive together.
            haddr_r     <= {address[31:2], be_dec_s.lo};
            hsize_r     <= be_dec_s.size;
            hwrite_r    <= write;
            hwdata_r    <= writedata;
            write_dir_r <= write;
         end else begin
            haddr_r     <= haddr_r;
            hsize_r     <= hsize_r;
            hwrite_r    <= hwrite_r;
            hwdata_r    <= hwdata_r;
            write_dir_r <= write_dir_r;
         end
      end
   end

   assign waitrequest   = waitrequest_r;
   assign readdata      = readdata_r;
   assign readdatavalid = readdatavalid_r;
   assign response      = response_r;
   assign wr_err        = wr_err_r;
   assign HADDR         = haddr_r;
   assign HTRANS        = htrans_r;
   assign HSIZE         = hsize_r;
   assign HBURST        = 3'b000;
   assign HPROT         = 4'b0011;
   assign HWRITE        = hwrite_r;
   assign HWDATA        = hwdata_r;

endmodule

// File: tb/tb_avalon_ahb_bridge.sv
// tb_avalon_ahb_bridge: directed checks of the Avalon-to-AHB bridge. Inputs change
// 1 time unit after each rising edge, and registered outputs are sampled there.
module tb_avalon_ahb_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic [1:0]  response;
   logic        wr_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int checks = 0;
   int errors = 0;

   avalon_ahb_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
      .readdata(readdata), .readdatavalid(readdatavalid), .response(response),
      .wr_err(wr_err), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "simulation time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
      read       = rd;
      write      = wr;
      address    = a;
      byteenable = be;
      writedata  = wd;
   endtask

   task automatic drop_cmd();
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_wreq"},   waitrequest,   32'd1);
      chk({p, "_rdv"},    readdatavalid, 32'd0);
      chk({p, "_wrerr"},  wr_err,        32'd0);
      chk({p, "_resp"},   response,      32'd0);
      chk({p, "_rdata"},  readdata,      32'h0);
      chk({p, "_htrans"}, HTRANS,        32'd0);
      chk({p, "_haddr"},  HADDR,         32'h0);
      chk({p, "_hsize"},  HSIZE,         32'd0);
      chk({p, "_hwrite"}, HWRITE,        32'd0);
      chk({p, "_hwdata"}, HWDATA,        32'h0);
      chk({p, "_hburst"}, HBURST,        32'd0);
      chk({p, "_hprot"},  HPROT,         32'd3);
   endtask

   initial begin
      rst = 1'b1;
      issue(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      HRDATA = 32'h0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      step();
      step();
      chk_reset("rst");

      // Release: waitrequest low on the first cycle after rst drops.
      rst = 1'b0;
      step();
      chk("rel_wreq", waitrequest, 32'd0);

      // Word read 0x1004, HREADY always 1.
      issue(1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0);
      step();
      drop_cmd();
      HRDATA = 32'hDEAD_BEEF;
      chk("wr1_htrans", HTRANS, 32'd2);
      chk("wr1_haddr", HADDR, 32'h0000_1004);
      chk("wr1_hsize", HSIZE, 32'd2);
      chk("wr1_hwrite", HWRITE, 32'd0);
      chk("wr1_wreq", waitrequest, 32'd1);
      step();
      chk("wr1_data_htrans", HTRANS, 32'd0);
      chk("wr1_data_rdv", readdatavalid, 32'd0);
      step();
      chk("wr1_rdv", readdatavalid, 32'd1);
      chk("wr1_rdata", readdata, 32'hDEAD_BEEF);
      chk("wr1_resp", response, 32'd0);
      step();
      chk("wr1_rdv_end", readdatavalid, 32'd0);
      chk("wr1_next_wreq", waitrequest, 32'd0);

      // Byte write 0x2000, lane 2.
      issue(1'b0, 1'b1, 32'h0000_2000, 4'b0100, 32'h00AB_0000);
      HRDATA = 32'h0;
      step();
      drop_cmd();
      chk("bw_htrans", HTRANS, 32'd2);
      chk("bw_haddr", HADDR, 32'h0000_2002);
      chk("bw_hsize", HSIZE, 32'd0);
      chk("bw_hwrite", HWRITE, 32'd1);
      step();
      chk("bw_hwdata", HWDATA, 32'h00AB_0000);
      chk("bw_data_htrans", HTRANS, 32'd0);
      step();
      chk("bw_wrerr", wr_err, 32'd0);
      chk("bw_wreq", waitrequest, 32'd0);

      // Halfword read with 3 wait states then a two-cycle error response.
      issue(1'b1, 1'b0, 32'h0000_3008, 4'b1100, 32'h0);
      step();
      drop_cmd();
      chk("err_haddr", HADDR, 32'h0000_300A);
      chk("err_hsize", HSIZE, 32'd1);
      chk("err_htrans", HTRANS, 32'd2);
      step();
      HRDATA = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         HREADY = (i == 4);
         HRESP  = (i >= 3);
         chk("err_wait_wreq", waitrequest, 32'd1);
         chk("err_wait_rdv", readdatavalid, 32'd0);
         chk("err_wait_htrans", HTRANS, 32'd0);
         step();
      end
      HREADY = 1'b1;
      HRESP  = 1'b0;
      chk("err_rdv", readdatavalid, 32'd1);
      chk("err_resp", response, 32'd2);
      chk("err_rdata", readdata, 32'h1234_5678);
      chk("err_resp_wreq", waitrequest, 32'd1);
      step();
      chk("err_rdv_once", readdatavalid, 32'd0);
      chk("err_idle_wreq", waitrequest, 32'd0);

      // Non-contiguous write: no transfer, one wr_err, re-accept two cycles later.
      issue(1'b0, 1'b1, 32'h0000_4000, 4'b0101, 32'h5555_5555);
      step();
      drop_cmd();
      chk("nc_htrans", HTRANS, 32'd0);
      chk("nc_wrerr", wr_err, 32'd1);
      chk("nc_wreq", waitrequest, 32'd1);
      step();
      chk("nc_wrerr_once", wr_err, 32'd0);
      chk("nc_wreq_low", waitrequest, 32'd0);
      chk("nc_htrans2", HTRANS, 32'd0);
      issue(1'b1, 1'b0, 32'h0000_5000, 4'b0001, 32'h0);
      HRDATA = 32'h0000_00A5;
      step();
      drop_cmd();
      chk("br_htrans", HTRANS, 32'd2);
      chk("br_haddr", HADDR, 32'h0000_5000);
      chk("br_hsize", HSIZE, 32'd0);
      step();
      step();
      chk("br_rdv", readdatavalid, 32'd1);
      chk("br_rdata", readdata, 32'h0000_00A5);
      chk("br_resp", response, 32'd0);
      step();

      // Three-lane read: immediate SLVERR, zero data, no transfer.
      issue(1'b1, 1'b0, 32'h0000_5100, 4'b0111, 32'h0);
      step();
      drop_cmd();
      chk("u3_rdv", readdatavalid, 32'd1);
      chk("u3_rdata", readdata, 32'h0);
      chk("u3_resp", response, 32'd2);
      chk("u3_htrans", HTRANS, 32'd0);
      step();
      chk("u3_rdv_end", readdatavalid, 32'd0);
      chk("u3_wreq", waitrequest, 32'd0);

      // Byte write with slave error; read+write together takes the write.
      issue(1'b1, 1'b1, 32'h0000_6001, 4'b0010, 32'h0000_7700);
      step();
      drop_cmd();
      chk("we_hwrite", HWRITE, 32'd1);
      chk("we_haddr", HADDR, 32'h0000_6001);
      step();
      HRESP = 1'b1;
      chk("we_hwdata", HWDATA, 32'h0000_7700);
      step();
      HRESP = 1'b0;
      chk("we_wrerr", wr_err, 32'd1);
      chk("we_rdv", readdatavalid, 32'd0);
      step();
      chk("we_wrerr_once", wr_err, 32'd0);

      // Reset during a stalled read data phase.
      issue(1'b1, 1'b0, 32'h0000_7000, 4'hF, 32'h0);
      step();
      drop_cmd();
      step();
      HREADY = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk_reset("mid");
      rst    = 1'b0;
      HREADY = 1'b1;
      step();
      chk("mid_rel_wreq", waitrequest, 32'd0);
      chk("mid_rel_rdv", readdatavalid, 32'd0);
      issue(1'b1, 1'b0, 32'h0000_7004, 4'hF, 32'h0);
      HRDATA = 32'hCAFE_F00D;
      step();
      drop_cmd();
      chk("post_htrans", HTRANS, 32'd2);
      chk("post_haddr", HADDR, 32'h0000_7004);
      step();
      step();
      chk("post_rdv", readdatavalid, 32'd1);
      chk("post_rdata", readdata, 32'hCAFE_F00D);
      chk("post_resp", response, 32'd0);
      step();

`ifdef AVL_AHB_TIMEOUT_EN
      // Watchdog: HREADY held low in DATA, limit 8.
      issue(1'b1, 1'b0, 32'h0000_8000, 4'hF, 32'h0);
      HRDATA = 32'h1111_2222;
      step();
      drop_cmd();
      step();
      HREADY = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("tmo_wait_rdv", readdatavalid, 32'd0);
      end
      step();
      chk("tmo_rdv", readdatavalid, 32'd1);
      chk("tmo_resp", response, 32'd2);
      chk("tmo_rdata", readdata, 32'h0);
      HREADY = 1'b1;
      step();
      chk("tmo_rdv_end", readdatavalid, 32'd0);
      chk("tmo_wreq", waitrequest, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
